// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
//   sched_state_t    : TX scheduler FSM states
//   DATA_BIT_DEFAULT : payload bits per frame
//   CLKDIV           : system clocks per bit, shared by the TX and RX engines
package uart_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

    localparam int DATA_BIT_DEFAULT = 8;
    localparam int CLK_HZ           = 50_000_000;
    localparam int BAUD             = 115_200;
    localparam int CLKDIV           = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        in  N          request vector
//   ptr        in  $clog2(N)  highest-priority index
//   gnt_onehot out N          one-hot grant (zero when no request)
//   gnt_idx    out $clog2(N)  index of the grant
//   any        out 1          at least one request pending
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Scan offsets from farthest to nearest so the closest request at or
    // after ptr is the one left standing.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        idx        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX engine between requesters.
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  NUM_REQ           requester has a byte pending
//   req_data     in  NUM_REQ*DATA_BIT  byte of requester i at [i*DATA_BIT +: DATA_BIT]
//   req_ready    out NUM_REQ           one-hot accept pulse
//   tx_start     out 1                 begin-frame pulse to the TX engine
//   tx_data      out DATA_BIT          frame byte, valid with tx_start and held after
//   tx_busy      in  1                 TX engine shifting
//   tx_done      in  1                 frame complete pulse
//   active_id    out $clog2(NUM_REQ)   current/last grant
//   busy         out 1                 scheduler not idle
//   err_timeout  out 1                 sticky watchdog expiry
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_BIT    = DATA_BIT_DEFAULT,
    parameter int NUM_REQ     = 4,
    parameter int BURST_MAX   = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BIT-1:0]          tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   active_id,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    sched_state_t        state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [WW-1:0]       wdog_q, wdog_d;
    logic [DATA_BIT-1:0] tx_data_q, tx_data_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  arb_onehot;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                arb_go, cont, expired;
    logic [BW-1:0]       burst_inc;
    logic [IW-1:0]       next_ptr;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    assign arb_go    = (state_q == IDLE) && !tx_busy && arb_any;
    assign burst_inc = burst_q + 1'b1;
    // Stay on the same requester only while it still has data and budget remains.
    assign cont      = req_valid[grant_q] && (burst_inc < BW'(BURST_MAX));
    assign expired   = wdog_q == WW'(TIMEOUT_CYC - 1);
    assign next_ptr  = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb_go ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            // tx_done is checked first so a coincident expiry is not an error.
            WAIT:    state_d = tx_done ? (cont ? ISSUE : IDLE) : (expired ? IDLE : WAIT);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start  = state_q == ISSUE;
        req_ready = tx_start ? grant_oh_q : '0;
        tx_data_d = tx_start ? req_data[int'(grant_q)*DATA_BIT +: DATA_BIT] : tx_data_q;
        tx_data   = tx_data_d;
        active_id = grant_q;
        busy      = state_q != IDLE;
        err_timeout = err_q;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        burst_d    = burst_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        if (arb_go) begin
            grant_d    = arb_idx;
            grant_oh_d = arb_onehot;
            burst_d    = '0;
        end
        if (state_q == ISSUE) wdog_d = '0;
        if (state_q == WAIT) begin
            wdog_d = wdog_q + 1'b1;
            if (tx_done) begin
                burst_d = burst_inc;
                if (!cont) rr_ptr_d = next_ptr;
            end else if (expired) begin
                // The hung byte is dropped; rotate so others are not starved.
                err_d    = 1'b1;
                rr_ptr_d = next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            burst_q    <= '0;
            wdog_q     <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            burst_q    <= burst_d;
            wdog_q     <= wdog_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with a transaction-level reference model.
module tb_uart_tx_scheduler;

    localparam int N = 4, DB = 8, BM = 4, TO = 50, HANG = TO + 10;

    logic            clk = 1'b0, rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start, tx_busy = 1'b0, tx_done = 1'b0, busy, err_timeout;
    logic [DB-1:0]   tx_data;
    logic [1:0]      active_id;

    int errs = 0, checks = 0, cyc = 0, last_start = -1, m_ptr = 0;
    logic exp_err = 1'b0;
    bit   eng_idle = 1'b1;
    logic [7:0] rmem [N][256];
    int rhead [N], rtail [N];
    int exp_id [$];
    logic [7:0] exp_dat [$];
    int fates [$], force_fates [$];

    uart_tx_scheduler #(.DATA_BIT(DB), .NUM_REQ(N), .BURST_MAX(BM), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .active_id(active_id),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int rand_fate();
        int r;
        r = int'($urandom_range(0, 19));
        return r == 0 ? HANG : r == 1 ? TO : int'($urandom_range(1, 12));
    endfunction

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
    endtask

    task automatic load(input int i, input logic [7:0] b);
        rmem[i][rtail[i]] = b;
        rtail[i]++;
    endtask

    // Reference model: replays the phase's byte queues under the round-robin,
    // burst and watchdog rules, pushing the expected grant/byte sequence.
    task automatic plan();
        int h [N];
        int t [N];
        int g, b, f, j;
        bit arb, more, found;
        g = 0; b = 0; arb = 1'b1;
        for (int i = 0; i < N; i++) begin
            h[i] = rhead[i];
            t[i] = rtail[i];
        end
        while (1) begin
            more = 1'b0;
            for (int i = 0; i < N; i++) if (h[i] != t[i]) more = 1'b1;
            if (!more) break;
            if (arb) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && h[j] != t[j]) begin
                        g = j;
                        found = 1'b1;
                    end
                end
                b = 0;
            end
            exp_id.push_back(g);
            exp_dat.push_back(rmem[g][h[g]]);
            h[g]++;
            f = force_fates.size() != 0 ? force_fates.pop_front() : rand_fate();
            fates.push_back(f);
            if (f <= TO) begin
                b++;
                arb = !(h[g] != t[g] && b < BM);
            end else arb = 1'b1;
            if (arb) m_ptr = (g + 1) % N;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_id.size() != 0 || !eng_idle || tx_busy || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            errs++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_id.size());
            exp_id.delete();
            exp_dat.delete();
            fates.delete();
        end
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("err_sticky", err_timeout, exp_err);
    endtask

    // Requesters: valid while a byte is queued; pop on accept.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) if (req_ready[i] && rhead[i] != rtail[i]) rhead[i]++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = rhead[i] != rtail[i];
            req_data[i*DB +: DB] = rmem[i][rhead[i]];
        end
    end

    // TX engine: tx_done d cycles after tx_start, or hangs busy without tx_done.
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            int d;
            d = fates.size() != 0 ? fates.pop_front() : 5;
            eng_idle = 1'b0;
            if (d <= TO) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (d - 1) @(posedge clk);
                #1;
                tx_busy = 1'b0;
                tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
                if (d == TO) chk("coincident_done_no_err", err_timeout, exp_err);
            end else begin
                for (int k = 1; k <= 60; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == 1) tx_busy = 1'b1;
                    if (k == 50) chk("err_before_expiry", err_timeout, exp_err);
                    if (k == 51) begin
                        exp_err = 1'b1;
                        chk("err_at_expiry", err_timeout, 1);
                    end
                end
                tx_busy = 1'b0;
            end
            eng_idle = 1'b1;
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each tx_start.
    initial forever begin
        @(negedge clk);
        chk("ready_vs_start", {$onehot0(req_ready), req_ready != 0}, {1'b1, tx_start});
        if (tx_start) begin
            last_start = cyc;
            if (exp_id.size() == 0) begin
                errs++;
                checks++;
                $display("FAIL unexpected_start: got id %0d data 0x%0h expected none", active_id, tx_data);
            end else begin
                int id;
                logic [7:0] dv;
                id = exp_id.pop_front();
                dv = exp_dat.pop_front();
                chk("tx_data", tx_data, dv);
                chk("active_id", active_id, id);
                chk("req_ready", req_ready, 1 << id);
                chk("busy_in_issue", busy, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int vcyc, t;
        clear_q();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {tx_start, req_ready, tx_data, active_id, busy, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single requester: one-cycle latency, byte and id presented.
        clear_q();
        load(2, 8'h5A);
        force_fates.push_back(10);
        plan();
        @(negedge clk);
        for (int i = 0; i < 10 && req_valid == 0; i++) @(negedge clk);
        vcyc = cyc;
        chk("no_early_start", tx_start, 0);
        @(negedge clk);
        chk("start_latency", {tx_start, 32'(cyc - vcyc)}, {1'b1, 32'd1});
        drain();

        // Wrap from pointer 3 with requesters 0 and 1 pending.
        clear_q();
        load(0, 8'h11);
        load(1, 8'h22);
        force_fates.push_back(3);
        force_fates.push_back(3);
        plan();
        drain();

        // All requesters with two bytes each.
        clear_q();
        for (int i = 0; i < N; i++) begin
            load(i, 8'($urandom));
            load(i, 8'($urandom));
        end
        plan();
        drain();

        // Park the pointer at 1, then a 6-byte burst on 1 against one byte on 3.
        clear_q();
        load(0, 8'h77);
        force_fates.push_back(2);
        plan();
        drain();
        clear_q();
        for (int i = 0; i < 6; i++) load(1, 8'(8'h30 + i));
        load(3, 8'hC3);
        for (int i = 0; i < 7; i++) force_fates.push_back(4);
        plan();
        drain();

        // tx_done on the last watchdog cycle, then a hung frame.
        clear_q();
        load(2, 8'hE1);
        force_fates.push_back(TO);
        plan();
        drain();
        clear_q();
        load(0, 8'h01);
        load(0, 8'h02);
        load(1, 8'h03);
        force_fates.push_back(HANG);
        force_fates.push_back(4);
        force_fates.push_back(4);
        plan();
        drain();

        // Randomized phases.
        for (int p = 0; p < 25; p++) begin
            clear_q();
            for (int i = 0; i < N; i++) begin
                int nb;
                nb = int'($urandom_range(0, 3));
                for (int k = 0; k < nb; k++) load(i, 8'($urandom));
            end
            plan();
            drain();
        end

        // Reset during WAIT; the engine finishes its frame before the next issue.
        clear_q();
        load(1, 8'hA5);
        load(1, 8'h3C);
        exp_id.push_back(1);
        exp_dat.push_back(8'hA5);
        exp_id.push_back(1);
        exp_dat.push_back(8'h3C);
        fates.push_back(20);
        fates.push_back(5);
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            @(negedge clk);
            if (tx_start) t = cyc;
        end
        chk("reset_test_start_seen", t >= 0, 1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {tx_start, req_ready, tx_data, active_id, busy, err_timeout}, 0);
        exp_err = 1'b0;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain();
        chk("restart_after_busy", last_start, t + 21);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
